// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_param
// Brief    : Parameterised UART / RS-485 transmitter, optional parity, 1-2 stops
// Revision : 1.0
// ============================================================================
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 rs485_tx,
  output logic                 rs485_de,
  output logic                 busy,
  output logic                 done
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic              PAR_ODD   = (PARITY == 2);
  localparam logic              PAR_EN    = (PARITY != 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 de_q, de_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    de_d       = de_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        de_d = 1'b0;
        // ready is still low on the first edge after reset, so nothing is accepted there
        if (valid && ready_q) begin
          state_d  = S_START;
          shift_d  = data;
          parity_d = (^data) ^ PAR_ODD;
          baud_d   = '0;
          tx_d     = 1'b0;
          de_d     = 1'b1;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == BIT_LAST) begin
            if (PAR_EN) begin
              state_d = S_PAR;
              tx_d    = parity_q;
            end else begin
              state_d    = S_STOP;
              stop_idx_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            de_d    = 1'b0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        de_d    = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      de_q       <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      de_q       <= de_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rs485_tx = tx_q;
  assign rs485_de = de_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// Bench for uart_tx_param: six parameter sets, each with random traffic compared
// every cycle against a frame-level model, plus literal reference frames.
module tb_uart_tx_param;

  localparam int NCFG = 6;

  function automatic int cfg_db(input int i);
    case (i)
      3:       return 7;
      4:       return 5;
      5:       return 9;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_par(input int i);
    case (i)
      1, 4:    return 1;
      2, 5:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_sb(input int i);
    case (i)
      3, 4:    return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_cpb(input int i);
    case (i)
      4:       return 1;
      5:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [8:0] cfg_word(input int i);
    case (i)
      0:       return 9'h055;
      1, 2:    return 9'h007;
      3:       return 9'h07F;
      4:       return 9'h013;
      default: return 9'h1A5;
    endcase
  endfunction

  // Hand-derived line bits (start, data LSB first, parity, stops) per config
  function automatic string cfg_seq(input int i);
    case (i)
      0:       return "0101010101";
      1:       return "01110000011";
      2:       return "01110000001";
      3:       return "0111111111";
      4:       return "011001111";
      default: return "010100101101";
    endcase
  endfunction

  function automatic int cfg_f(input int i);
    case (i)
      0, 3:    return 40;
      1, 2:    return 44;
      4:       return 9;
      default: return 36;
    endcase
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check1(input string name, input int cfg, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %b expected %b at %0t", cfg, name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int cfg, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0d expected %0d", cfg, name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input int cfg, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %s expected %s", cfg, name, act, exp);
    end
  endtask

  logic clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int DB  = cfg_db(g);
    localparam int PAR = cfg_par(g);
    localparam int SB  = cfg_sb(g);
    localparam int CPB = cfg_cpb(g);
    localparam int NB  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int F   = NB * CPB;

    logic          rst     = 1'b1;
    logic          valid_r = 1'b0;
    logic [DB-1:0] data_r  = '0;
    logic          ready, tx, de, busy, done;
    bit            fin_b   = 1'b0;

    uart_tx_param #(
      .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .CLKS_PER_BIT(CPB)
    ) u_dut (
      .clk(clk), .RST(rst), .data(data_r), .valid(valid_r),
      .ready(ready), .rs485_tx(tx), .rs485_de(de), .busy(busy), .done(done)
    );

    // Frame-level model: a list of line bits plus a cycle count since acceptance
    bit m_in    = 1'b0;
    bit m_ready = 1'b0;
    bit m_done  = 1'b0;
    int m_cyc   = 0;
    bit m_bits[NB];

    always @(posedge clk) begin
      if (rst) begin
        m_in = 1'b0; m_ready = 1'b0; m_done = 1'b0;
      end else if (m_in) begin
        m_cyc++;
        if (m_cyc == F) begin
          m_in = 1'b0; m_ready = 1'b1; m_done = 1'b1;
        end
      end else begin
        m_done = 1'b0;
        if (m_ready && valid_r) begin
          m_bits[0] = 1'b0;
          for (int k = 0; k < DB; k++) m_bits[1 + k] = data_r[k];
          if (PAR != 0) m_bits[1 + DB] = (^data_r) ^ (PAR == 2);
          for (int k = NB - SB; k < NB; k++) m_bits[k] = 1'b1;
          m_in = 1'b1; m_cyc = 0; m_ready = 1'b0;
        end else begin
          m_ready = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        m_in = 1'b0; m_ready = 1'b0; m_done = 1'b0;
        check1("rst_tx", g, tx, 1'b1);
        check1("rst_de", g, de, 1'b0);
        check1("rst_ready", g, ready, 1'b0);
        check1("rst_busy", g, busy, 1'b0);
        check1("rst_done", g, done, 1'b0);
      end else begin
        check1("tx", g, tx, m_in ? m_bits[m_cyc / CPB] : 1'b1);
        check1("de", g, de, m_in);
        check1("busy", g, busy, m_in);
        check1("ready", g, ready, !m_in && m_ready);
        check1("done", g, done, m_done);
      end
    end

    task automatic wait_ready();
      int t = 0;
      while (!ready && t < 400) begin
        @(posedge clk); #2;
        t++;
      end
      if (!ready) check1("ready_timeout", g, ready, 1'b1);
    endtask

    task automatic send_check();
      string seq = cfg_seq(g);
      string got = "";
      int done_at = -1;
      int de_cnt = 0;
      wait_ready();
      data_r  = DB'(cfg_word(g));
      valid_r = 1'b1;
      @(posedge clk); #2;
      valid_r = 1'b0;
      data_r  = ~data_r;
      for (int e = 0; e < F + 4; e++) begin
        @(negedge clk);
        if ((e % CPB) == (CPB / 2) && (e / CPB) < seq.len()) got = {got, tx ? "1" : "0"};
        if (done && done_at < 0) done_at = e;
        if (de) de_cnt++;
      end
      @(posedge clk); #2;
      check_str("line_bits", g, got, seq);
      check_int("done_cycle", g, done_at, cfg_f(g));
      check_int("de_cycles", g, de_cnt, cfg_f(g));
      check1("ready_after", g, ready, 1'b1);
    endtask

    task automatic b2b();
      int first = -1;
      int second = -1;
      wait_ready();
      data_r  = DB'($urandom);
      valid_r = 1'b1;
      for (int e = 0; e < 3 * F + 10 && second < 0; e++) begin
        @(negedge clk);
        if (done) begin
          if (first < 0) begin
            first  = e;
            data_r = DB'($urandom);
          end else begin
            second = e;
          end
        end
      end
      valid_r = 1'b0;
      @(posedge clk); #2;
      check_int("done_gap", g, second - first, cfg_f(g) + 1);
    endtask

    task automatic mid_reset();
      wait_ready();
      data_r  = DB'(9'h0F0);
      valid_r = 1'b1;
      @(posedge clk); #2;
      valid_r = 1'b0;
      repeat (4 * CPB) @(posedge clk);
      #1;
      check1("tx_bit3", g, tx, 1'b0);
      #1 rst = 1'b1;
      #1;
      check1("abort_tx", g, tx, 1'b1);
      check1("abort_de", g, de, 1'b0);
      check1("abort_busy", g, busy, 1'b0);
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      check1("ready_held", g, ready, 1'b0);
      @(posedge clk); #1;
      check1("ready_release", g, ready, 1'b1);
      check1("no_done", g, done, 1'b0);
      #1;
    endtask

    initial begin
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      send_check();
      b2b();
      mid_reset();
      send_check();
      for (int c = 0; c < 1500; c++) begin
        valid_r = ($urandom_range(0, 3) != 0);
        data_r  = DB'($urandom);
        if ($urandom_range(0, 499) == 0) begin
          rst = 1'b1;
          @(posedge clk);
          @(posedge clk); #2;
          rst = 1'b0;
        end else begin
          @(posedge clk); #2;
        end
      end
      valid_r = 1'b0;
      repeat (2 * F + 4) @(posedge clk);
      fin_b = 1'b1;
    end
  end

  initial begin
    int t = 0;
    bit all_fin = 1'b0;
    while (!all_fin && t < 50000) begin
      @(posedge clk);
      t++;
      all_fin = g_cfg[0].fin_b && g_cfg[1].fin_b && g_cfg[2].fin_b &&
                g_cfg[3].fin_b && g_cfg[4].fin_b && g_cfg[5].fin_b;
    end
    if (!all_fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d cycles expected completion", t);
    end
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
